// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter: round-robin arbiter that frames a 48-bit payload from one of two
// requesters into an 8-byte SPART frame, one byte per tbr handshake.
module tx_packet_arbiter #(
    parameter logic [7:0] START1 = 8'hBA,
    parameter logic [7:0] START2 = 8'h11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [47:0] payload0,
    input  logic [47:0] payload1,
    input  logic        tbr,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, GRANT, WAIT_TBR, WRITE, HOLD} state_t;
    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        lsp_q, lsp_d;
    logic        win_q, win_d;
    logic [47:0] payload_q, payload_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [63:0] frame;
    logic        last;

    assign frame = {START1, START2, payload_q} << {idx_q, 3'b000};
    assign last  = idx_q == 3'd7;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            lsp_q     <= 1'b1;
            win_q     <= 1'b0;
            payload_q <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lsp_q     <= lsp_d;
            win_q     <= win_d;
            payload_q <= payload_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lsp_d     = lsp_q;
        win_d     = win_q;
        payload_d = payload_q;
        tx_data_d = tx_data_q;
        case (state_q)
            IDLE: if (req0 || req1) begin
                win_d   = (req0 && req1) ? ~lsp_q : req1;
                state_d = GRANT;
            end
            GRANT: begin
                payload_d = win_q ? payload1 : payload0;
                idx_d     = '0;
                state_d   = WAIT_TBR;
            end
            WAIT_TBR: if (tbr) begin
                tx_data_d = frame[63:56];
                state_d   = WRITE;
            end
            WRITE: state_d = HOLD;
            // HOLD gives tbr a cycle to fall after a write before it is sampled again
            HOLD: begin
                idx_d   = last ? idx_q : idx_q + 3'd1;
                lsp_d   = last ? win_q : lsp_q;
                state_d = last ? IDLE : WAIT_TBR;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt0    = state_q == GRANT && !win_q;
    assign gnt1    = state_q == GRANT && win_q;
    assign done0   = state_q == HOLD && last && !win_q;
    assign done1   = state_q == HOLD && last && win_q;
    assign tx_wr   = state_q == WRITE;
    assign busy    = state_q != IDLE;
    assign tx_data = tx_data_q;
endmodule
